// File: rtl/uart_hex_rx_fsm_if.sv
// Byte-in / record-out bus between the UART RX core, the hex record parser and the write-side FIFO.
interface uart_hex_rx_fsm_if #(
  parameter int unsigned FIFO_WR_DATA_WIDTH = 96
);
  logic                          fsm_en;
  logic                          uart_rx_valid;
  logic [7:0]                    uart_rx_dout;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [FIFO_WR_DATA_WIDTH-1:0] fifo_wr_data;
  logic                          parse_err;
  logic [7:0]                    err_cnt;

  modport master (
    output fsm_en, uart_rx_valid, uart_rx_dout, fifo_full,
    input  fifo_wr_en, fifo_wr_data, parse_err, err_cnt
  );

  modport slave (
    input  fsm_en, uart_rx_valid, uart_rx_dout, fifo_full,
    output fifo_wr_en, fifo_wr_data, parse_err, err_cnt
  );
endinterface

// File: rtl/uart_hex_rx_fsm.sv
// Parses "XXXXXXXX,...,XXXXXXXX\r\n" ASCII hex records into FIFO words.
// Define UART_HEX_RX_LOWERCASE_EN to also accept 'a'-'f' as hex digits.
module uart_hex_rx_fsm #(
  parameter int unsigned FIFO_WR_DATA_WIDTH = 96
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_hex_rx_fsm_if.slave  bus
);
  localparam int unsigned W         = FIFO_WR_DATA_WIDTH;
  localparam int unsigned NUM_WORDS = W / 32;
  localparam int unsigned WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [2:0] {
    IDLE, RECV_WORD, EXPECT_COMMA, EXPECT_CR, EXPECT_LF, WRITE_FIFO, RESYNC
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        digit_cnt, digit_nxt;
  logic [WCNT_W-1:0] word_cnt, word_nxt;
  logic [W-1:0]      data;
  logic              perr;
  logic [7:0]        ecnt;

  logic       is_hex_c, is_cr_c, is_lf_c, is_comma_c;
  logic [3:0] nib_c;
  logic       shift_c, bad_c, err_c;

  // ASCII hex digit decode
  always_comb begin
    is_hex_c = 1'b0;
    nib_c    = 4'h0;
    if (bus.uart_rx_dout >= 8'h30 && bus.uart_rx_dout <= 8'h39) begin
      is_hex_c = 1'b1;
      nib_c    = 4'(bus.uart_rx_dout - 8'h30);
    end else if (bus.uart_rx_dout >= 8'h41 && bus.uart_rx_dout <= 8'h46) begin
      is_hex_c = 1'b1;
      nib_c    = 4'(bus.uart_rx_dout - 8'h37);
    end
`ifdef UART_HEX_RX_LOWERCASE_EN
    else if (bus.uart_rx_dout >= 8'h61 && bus.uart_rx_dout <= 8'h66) begin
      is_hex_c = 1'b1;
      nib_c    = 4'(bus.uart_rx_dout - 8'h57);
    end
`else
    else begin
      is_hex_c = 1'b0;
    end
`endif
  end

  assign is_cr_c    = (bus.uart_rx_dout == CH_CR);
  assign is_lf_c    = (bus.uart_rx_dout == CH_LF);
  assign is_comma_c = (bus.uart_rx_dout == CH_COMMA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, counter updates and error detection
  always_comb begin
    state_nxt = state;
    digit_nxt = digit_cnt;
    word_nxt  = word_cnt;
    shift_c   = 1'b0;
    bad_c     = 1'b0;
    err_c     = 1'b0;
    if (!bus.fsm_en) begin
      state_nxt = IDLE;
      digit_nxt = 3'd0;
      word_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          digit_nxt = 3'd0;
          word_nxt  = '0;
          if (bus.uart_rx_valid) begin
            if (is_hex_c) begin
              shift_c   = 1'b1;
              digit_nxt = 3'd1;
              state_nxt = RECV_WORD;
            end else if (!(is_cr_c || is_lf_c)) begin
              bad_c = 1'b1;
            end
          end
        end
        RECV_WORD: begin
          if (bus.uart_rx_valid) begin
            if (is_hex_c) begin
              shift_c = 1'b1;
              if (digit_cnt == 3'd7) begin
                digit_nxt = 3'd0;
                state_nxt = (word_cnt == LAST_WORD) ? EXPECT_CR : EXPECT_COMMA;
              end else begin
                digit_nxt = 3'(digit_cnt + 3'd1);
              end
            end else begin
              bad_c = 1'b1;
            end
          end
        end
        EXPECT_COMMA: begin
          if (bus.uart_rx_valid) begin
            if (is_comma_c) begin
              word_nxt  = WCNT_W'(word_cnt + 1'b1);
              digit_nxt = 3'd0;
              state_nxt = RECV_WORD;
            end else begin
              bad_c = 1'b1;
            end
          end
        end
        EXPECT_CR: begin
          if (bus.uart_rx_valid) begin
            if (is_cr_c) state_nxt = EXPECT_LF;
            else         bad_c     = 1'b1;
          end
        end
        EXPECT_LF: begin
          if (bus.uart_rx_valid) begin
            if (is_lf_c) state_nxt = WRITE_FIFO;
            else         bad_c     = 1'b1;
          end
        end
        WRITE_FIFO: begin
          if (!bus.fifo_full) state_nxt = IDLE;
        end
        RESYNC: begin
          if (bus.uart_rx_valid && is_lf_c) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      // A bad LF already ends the line, so skip RESYNC and wait for the next record
      if (bad_c) begin
        err_c     = 1'b1;
        state_nxt = is_lf_c ? IDLE : RESYNC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_cnt <= 3'd0;
      word_cnt  <= '0;
      data      <= '0;
      perr      <= 1'b0;
      ecnt      <= 8'd0;
    end else begin
      digit_cnt <= digit_nxt;
      word_cnt  <= word_nxt;
      perr      <= err_c;
      if (shift_c)                  data <= {data[W-5:0], nib_c};
      if (err_c && ecnt != 8'hFF)   ecnt <= 8'(ecnt + 8'd1);
    end
  end

  // Write strobe follows the state directly; a dropped enable abandons the write
  assign bus.fifo_wr_en   = (state == WRITE_FIFO) && !bus.fifo_full && bus.fsm_en;
  assign bus.fifo_wr_data = data;
  assign bus.parse_err    = perr;
  assign bus.err_cnt      = ecnt;
endmodule

// File: tb/tb_uart_hex_rx_fsm.sv
// Directed bench for uart_hex_rx_fsm: record parsing, FIFO back-pressure, errors, enable and reset.
module tb_uart_hex_rx_fsm;
  localparam logic [95:0] REC1 = 96'hABCD0032839748AC8DFE3210;
  localparam logic [95:0] REC2 = 96'h000000010000000200000003;
  localparam logic [7:0]  CR   = 8'h0D;
  localparam logic [7:0]  LF   = 8'h0A;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_hex_rx_fsm_if #(.FIFO_WR_DATA_WIDTH(96)) bus ();

  uart_hex_rx_fsm #(.FIFO_WR_DATA_WIDTH(96)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int perr_cnt = 0;
  int exp_err  = 0;
  logic [95:0] wr_data = '0;

  // Observe pulses mid-cycle
  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_data = bus.fifo_wr_data;
    end
    if (bus.parse_err === 1'b1) perr_cnt = perr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_dout  = b;
    tick();
    bus.uart_rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), gap);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b exp 0", bus.fifo_wr_en); end
    checks++; if (bus.fifo_wr_data !== 96'h0) begin failures++; $display("FAIL reset_data got %h exp 0", bus.fifo_wr_data); end
    checks++; if (bus.parse_err !== 1'b0) begin failures++; $display("FAIL reset_parse_err got %b exp 0", bus.parse_err); end
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got %0d exp 0", bus.err_cnt); end
    reset_n = 1'b1;
    tick();
    exp_err = 0;
  endtask

  task automatic test_single_record();
    int w0 = wr_cnt;
    int p0 = perr_cnt;
    send_str("ABCD0032,839748AC,8DFE3210", 9);
    send_byte(CR, 9);
    send_byte(LF, 0);
    checks++; if (bus.fifo_wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en_after_lf got %b exp 1", bus.fifo_wr_en); end
    checks++; if (bus.fifo_wr_data !== REC1) begin failures++; $display("FAIL single_data got %h exp %h", bus.fifo_wr_data, REC1); end
    tick();
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL single_wr_en_one_cycle got %b exp 0", bus.fifo_wr_en); end
    repeat (10) tick();
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL single_wr_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_data !== REC1) begin failures++; $display("FAIL single_wr_data got %h exp %h", wr_data, REC1); end
    checks++; if (perr_cnt - p0 !== 0) begin failures++; $display("FAIL single_parse_err got %0d exp 0", perr_cnt - p0); end
  endtask

  task automatic test_fifo_full();
    int w0 = wr_cnt;
    bus.fifo_full = 1'b1;
    send_str("ABCD0032,839748AC,8DFE3210", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL full_wr_en_blocked got %b exp 0", bus.fifo_wr_en); end
    repeat (20) tick();
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL full_no_write got %0d exp 0", wr_cnt - w0); end
    bus.fifo_full = 1'b0;
    #1;
    checks++; if (bus.fifo_wr_en !== 1'b1) begin failures++; $display("FAIL full_release_wr_en got %b exp 1", bus.fifo_wr_en); end
    tick();
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL full_back_idle got %b exp 0", bus.fifo_wr_en); end
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL full_wr_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_data !== REC1) begin failures++; $display("FAIL full_wr_data got %h exp %h", wr_data, REC1); end
  endtask

  task automatic test_bad_digit();
    int w0 = wr_cnt;
    int p0 = perr_cnt;
    send_str("ABC", 0);
    send_byte(8'h47, 0);
    checks++; if (bus.parse_err !== 1'b1) begin failures++; $display("FAIL bad_digit_pulse got %b exp 1", bus.parse_err); end
    tick();
    checks++; if (bus.parse_err !== 1'b0) begin failures++; $display("FAIL bad_digit_pulse_width got %b exp 0", bus.parse_err); end
    send_str("0032,839748AC,8DFE3210", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    repeat (3) tick();
    exp_err = exp_err + 1;
    checks++; if (bus.err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL bad_digit_err_cnt got %0d exp %0d", bus.err_cnt, exp_err); end
    checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL bad_digit_pulses got %0d exp 1", perr_cnt - p0); end
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL bad_digit_no_write got %0d exp 0", wr_cnt - w0); end
    send_str("00000001,00000002,00000003", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    repeat (3) tick();
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL recover_wr_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_data !== REC2) begin failures++; $display("FAIL recover_wr_data got %h exp %h", wr_data, REC2); end
  endtask

  task automatic test_lowercase();
    int w0 = wr_cnt;
    int p0 = perr_cnt;
    send_str("abcd0032,839748ac,8dfe3210", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    repeat (3) tick();
`ifdef UART_HEX_RX_LOWERCASE_EN
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL lower_wr_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_data !== REC1) begin failures++; $display("FAIL lower_wr_data got %h exp %h", wr_data, REC1); end
    checks++; if (perr_cnt - p0 !== 0) begin failures++; $display("FAIL lower_parse_err got %0d exp 0", perr_cnt - p0); end
`else
    exp_err = exp_err + 1;
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL lower_no_write got %0d exp 0", wr_cnt - w0); end
    checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL lower_parse_err got %0d exp 1", perr_cnt - p0); end
`endif
    checks++; if (bus.err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL lower_err_cnt got %0d exp %0d", bus.err_cnt, exp_err); end
  endtask

  task automatic test_short_word();
    int w0 = wr_cnt;
    int p0 = perr_cnt;
    send_str("ABC", 0);
    send_byte(8'h2C, 0);
    checks++; if (bus.parse_err !== 1'b1) begin failures++; $display("FAIL short_pulse got %b exp 1", bus.parse_err); end
    send_str("839748AC,8DFE3210", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    repeat (3) tick();
    exp_err = exp_err + 1;
    checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL short_pulses got %0d exp 1", perr_cnt - p0); end
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL short_no_write got %0d exp 0", wr_cnt - w0); end
    checks++; if (bus.err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL short_err_cnt got %0d exp %0d", bus.err_cnt, exp_err); end
  endtask

  task automatic test_missing_cr();
    int w0 = wr_cnt;
    int p0 = perr_cnt;
    send_str("ABCD0032,839748AC,8DFE3210", 0);
    send_byte(LF, 0);
    checks++; if (bus.parse_err !== 1'b1) begin failures++; $display("FAIL nocr_pulse got %b exp 1", bus.parse_err); end
    send_str("00000001,00000002,00000003", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    repeat (3) tick();
    exp_err = exp_err + 1;
    checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL nocr_pulses got %0d exp 1", perr_cnt - p0); end
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL nocr_next_write got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_data !== REC2) begin failures++; $display("FAIL nocr_next_data got %h exp %h", wr_data, REC2); end
  endtask

  task automatic test_fsm_en();
    int w0 = wr_cnt;
    int p0 = perr_cnt;
    send_str("ABCD0032,839", 0);
    bus.fsm_en = 1'b0;
    repeat (3) tick();
    bus.fsm_en = 1'b1;
    repeat (3) tick();
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL en_partial_no_write got %0d exp 0", wr_cnt - w0); end
    checks++; if (perr_cnt - p0 !== 0) begin failures++; $display("FAIL en_partial_no_err got %0d exp 0", perr_cnt - p0); end
    bus.fsm_en = 1'b0;
    send_byte(8'h47, 0);
    bus.fsm_en = 1'b1;
    repeat (2) tick();
    checks++; if (perr_cnt - p0 !== 0) begin failures++; $display("FAIL en_same_edge_ignored got %0d exp 0", perr_cnt - p0); end
    bus.fifo_full = 1'b1;
    send_str("ABCD0032,839748AC,8DFE3210", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    tick();
    bus.fsm_en    = 1'b0;
    bus.fifo_full = 1'b0;
    tick();
    bus.fsm_en = 1'b1;
    repeat (3) tick();
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL en_write_abandoned got %0d exp 0", wr_cnt - w0); end
    send_str("00000001,00000002,00000003", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    repeat (3) tick();
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL en_next_write got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_data !== REC2) begin failures++; $display("FAIL en_next_data got %h exp %h", wr_data, REC2); end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    bus.fifo_full = 1'b1;
    send_str("ABCD0032,839748AC,8DFE3210", 0);
    send_byte(CR, 0);
    send_byte(LF, 0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.fifo_wr_data !== 96'h0) begin failures++; $display("FAIL rst_mid_data got %h exp 0", bus.fifo_wr_data); end
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL rst_mid_err_cnt got %0d exp 0", bus.err_cnt); end
    checks++; if (bus.parse_err !== 1'b0) begin failures++; $display("FAIL rst_mid_parse_err got %b exp 0", bus.parse_err); end
    bus.fifo_full = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_err = 0;
    repeat (3) tick();
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL rst_mid_no_write got %0d exp 0", wr_cnt - w0); end
    send_str("ABCD0032,839748AC,8DFE3210", 2);
    send_byte(CR, 2);
    send_byte(LF, 2);
    repeat (3) tick();
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL rst_next_write got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_data !== REC1) begin failures++; $display("FAIL rst_next_data got %h exp %h", wr_data, REC1); end
  endtask

  task automatic test_saturation();
    int w0 = wr_cnt;
    int p0 = perr_cnt;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h47, 0);
      send_byte(LF, 0);
    end
    repeat (2) tick();
    checks++; if (bus.err_cnt !== 8'd255) begin failures++; $display("FAIL sat_err_cnt got %0d exp 255", bus.err_cnt); end
    checks++; if (perr_cnt - p0 !== 300) begin failures++; $display("FAIL sat_pulses got %0d exp 300", perr_cnt - p0); end
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL sat_no_write got %0d exp 0", wr_cnt - w0); end
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.fsm_en        = 1'b1;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_dout  = 8'h00;
    bus.fifo_full     = 1'b0;
    tick();
    test_reset();
    test_single_record();
    test_fifo_full();
    test_bad_digit();
    test_lowercase();
    test_short_word();
    test_missing_cr();
    test_fsm_en();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
